// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the parametrised 16-bit SRAM controller.
// Beat helpers work on a fixed maximum of 8 beats (128-bit accesses).
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int MAX_BEATS  = 8;
  localparam int MASK_MAX_W = 2 * MAX_BEATS;
  // Beat indices must also hold MAX_BEATS itself, which means "no beat left".
  localparam int BEAT_W     = 4;
  localparam int WAIT_CNT_W = 3;

  function automatic logic [MAX_BEATS-1:0] beat_activity(input logic [MASK_MAX_W-1:0] bmask);
    logic [MAX_BEATS-1:0] act;
    for (int i = 0; i < MAX_BEATS; i++) begin
      act[i] = bmask[2*i] | bmask[2*i+1];
    end
    return act;
  endfunction

  function automatic logic [BEAT_W-1:0] next_active_beat(input logic [MAX_BEATS-1:0] mask,
                                                         input logic [BEAT_W-1:0]    from,
                                                         input logic                 skip,
                                                         input int                   beats);
    logic [BEAT_W-1:0] res;
    res = BEAT_W'(beats);
    for (int i = MAX_BEATS - 1; i >= 0; i--) begin
      if (i < beats && BEAT_W'(i) >= from && (mask[i] || !skip)) begin
        res = BEAT_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_ctrl_beat_timer.sv
// Wait-state counter and beat index for one SRAM access; flags the last
// cycle of each beat and the last cycle of the whole access.
module sram_beat_timer
  import sram_ctrl_pkg::*;
#(
  parameter int BEATS       = 2,
  parameter bit SKIP_MASKED = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [BEAT_W-1:0]     first_beat_i,
  input  logic                  run_i,
  input  logic [WAIT_CNT_W-1:0] wait_i,
  input  logic [MAX_BEATS-1:0]  act_i,
  output logic [BEAT_W-1:0]     beat_o,
  output logic                  beat_last_o,
  output logic                  access_last_o
);

  logic [BEAT_W-1:0]     beat_q, beat_d, next_beat;
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;

  assign beat_o        = beat_q;
  assign beat_last_o   = run_i && (wcnt_q == wait_i);
  assign next_beat     = next_active_beat(act_i, beat_q + BEAT_W'(1), SKIP_MASKED, BEATS);
  assign access_last_o = beat_last_o && (next_beat == BEAT_W'(BEATS));

  always_comb begin
    beat_d = beat_q;
    wcnt_d = wcnt_q;
    if (start_i) begin
      beat_d = first_beat_i;
      wcnt_d = '0;
    end else if (beat_last_o) begin
      beat_d = next_beat;
      wcnt_d = '0;
    end else if (run_i) begin
      wcnt_d = wcnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beat_q <= '0;
      wcnt_q <= '0;
    end else begin
      beat_q <= beat_d;
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/sram_ctrl_param.sv
// Valid/ready to asynchronous 16-bit SRAM bridge with configurable access
// width, per-beat wait states and optional skipping of fully masked beats.
module sram_ctrl_param
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_RD     = 0,
  parameter int WAIT_WR     = 0,
  parameter bit SKIP_MASKED = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [SRAM_AW:0]    i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_bmask,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_busy,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  inout  wire  [15:0]         SRAM_DQ,
  output logic                SRAM_CE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_UB_N
);

  localparam int BEATS = DATA_W / 16;
  localparam int BM_W  = DATA_W / 8;

  state_e                state_q;
  logic [SRAM_AW-1:0]    base_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [BM_W-1:0]       bmask_q;
  logic                  we_q;
  logic [DATA_W-1:0]     rbuf_q, rbuf_next;
  logic [DATA_W-1:0]     rdata_q;
  logic                  rsp_valid_q;

  logic                  active, start;
  logic [BEAT_W-1:0]     beat, first_beat;
  logic                  beat_last, access_last;
  logic [WAIT_CNT_W-1:0] wait_sel;
  logic [15:0]           wr_slice, rd_slice;
  logic [1:0]            lane_en;
  logic                  unused_addr_lsb;

  // Byte bit 0 never selects anything on a 16-bit bus.
  assign unused_addr_lsb = i_req_addr[0];

  assign active      = (state_q != IDLE);
  assign start       = (state_q == IDLE) && i_req_valid;
  assign first_beat  = next_active_beat(beat_activity(MASK_MAX_W'(i_req_bmask)), '0,
                                        SKIP_MASKED, BEATS);
  assign wait_sel    = we_q ? WAIT_CNT_W'(WAIT_WR) : WAIT_CNT_W'(WAIT_RD);

  sram_beat_timer #(
    .BEATS       (BEATS),
    .SKIP_MASKED (SKIP_MASKED)
  ) u_timer (
    .clk_i         (i_clk),
    .rst_n_i       (i_rst_n),
    .start_i       (start),
    .first_beat_i  (first_beat),
    .run_i         (active),
    .wait_i        (wait_sel),
    .act_i         (beat_activity(MASK_MAX_W'(bmask_q))),
    .beat_o        (beat),
    .beat_last_o   (beat_last),
    .access_last_o (access_last)
  );

  always_comb begin
    wr_slice  = '0;
    lane_en   = '0;
    rbuf_next = rbuf_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat == BEAT_W'(k)) begin
        wr_slice = wdata_q[16*k +: 16];
        lane_en  = bmask_q[2*k +: 2];
      end
    end
    rd_slice = SRAM_DQ & {{8{lane_en[1]}}, {8{lane_en[0]}}};
    for (int k = 0; k < BEATS; k++) begin
      if (beat == BEAT_W'(k)) begin
        rbuf_next[16*k +: 16] = rd_slice;
      end
    end
  end

  // Pins decode only registered state, so an asynchronous reset parks them at once.
  assign SRAM_ADDR = active ? base_q + SRAM_AW'(beat) : '0;
  assign SRAM_CE_N = !active;
  assign SRAM_OE_N = (state_q != READ);
  assign SRAM_WE_N = !((state_q == WRITE) && ((WAIT_WR == 0) || !beat_last));
  assign SRAM_UB_N = active ? !lane_en[1] : 1'b1;
  assign SRAM_LB_N = active ? !lane_en[0] : 1'b1;
  assign SRAM_DQ   = (state_q == WRITE) ? wr_slice : 16'hzzzz;

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = active;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      we_q        <= 1'b0;
      rbuf_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            base_q  <= i_req_addr[SRAM_AW:1] & ~SRAM_AW'(BEATS - 1);
            wdata_q <= i_req_wdata;
            bmask_q <= i_req_bmask;
            we_q    <= i_req_we;
            rbuf_q  <= '0;
            // Nothing to transfer: answer straight away without touching the bus.
            if (first_beat == BEAT_W'(BEATS)) begin
              rsp_valid_q <= 1'b1;
              if (!i_req_we) rdata_q <= '0;
            end else begin
              state_q <= i_req_we ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (access_last) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
          end
        end
        READ: begin
          if (beat_last) rbuf_q <= rbuf_next;
          if (access_last) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rbuf_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: a 32-bit zero-wait instance and a 64-bit
// wait-state instance, each with a behavioural SRAM and a response scoreboard.
module tb_sram_ctrl_param;

  typedef struct {
    bit          isRead;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  exp_t aExpQ[$];
  exp_t bExpQ[$];
  exp_t aExp, bExp;

  logic        aValid, aWe;
  logic [18:0] aAddr;
  logic [31:0] aWdata;
  logic [3:0]  aBmask;
  logic        aReady, aRspValid, aBusy;
  logic [31:0] aRdata;
  logic [17:0] aSramAddr;
  wire  [15:0] aDq;
  logic        aCeN, aWeN, aOeN, aLbN, aUbN;
  logic [15:0] aMem [0:4095];

  logic        bValid, bWe;
  logic [12:0] bAddr;
  logic [63:0] bWdata;
  logic [7:0]  bBmask;
  logic        bReady, bRspValid, bBusy;
  logic [63:0] bRdata;
  logic [11:0] bSramAddr;
  wire  [15:0] bDq;
  logic        bCeN, bWeN, bOeN, bLbN, bUbN;
  logic [15:0] bMem [0:4095];

  sram_ctrl_param #(
    .DATA_W(32), .SRAM_AW(18), .WAIT_RD(0), .WAIT_WR(0), .SKIP_MASKED(1'b1)
  ) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(aValid), .o_req_ready(aReady),
    .i_req_we(aWe), .i_req_addr(aAddr), .i_req_wdata(aWdata), .i_req_bmask(aBmask),
    .o_rsp_valid(aRspValid), .o_rsp_rdata(aRdata), .o_busy(aBusy),
    .SRAM_ADDR(aSramAddr), .SRAM_DQ(aDq), .SRAM_CE_N(aCeN), .SRAM_WE_N(aWeN),
    .SRAM_OE_N(aOeN), .SRAM_LB_N(aLbN), .SRAM_UB_N(aUbN)
  );

  sram_ctrl_param #(
    .DATA_W(64), .SRAM_AW(12), .WAIT_RD(2), .WAIT_WR(3), .SKIP_MASKED(1'b1)
  ) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(bValid), .o_req_ready(bReady),
    .i_req_we(bWe), .i_req_addr(bAddr), .i_req_wdata(bWdata), .i_req_bmask(bBmask),
    .o_rsp_valid(bRspValid), .o_rsp_rdata(bRdata), .o_busy(bBusy),
    .SRAM_ADDR(bSramAddr), .SRAM_DQ(bDq), .SRAM_CE_N(bCeN), .SRAM_WE_N(bWeN),
    .SRAM_OE_N(bOeN), .SRAM_LB_N(bLbN), .SRAM_UB_N(bUbN)
  );

  // Behavioural asynchronous SRAMs: drive on read, byte-lane write while WE_N is low.
  assign aDq = (!aCeN && !aOeN && aWeN) ? aMem[aSramAddr[11:0]] : 16'hzzzz;
  assign bDq = (!bCeN && !bOeN && bWeN) ? bMem[bSramAddr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!aCeN && !aWeN) begin
      if (!aLbN) aMem[aSramAddr[11:0]][7:0]  <= aDq[7:0];
      if (!aUbN) aMem[aSramAddr[11:0]][15:8] <= aDq[15:8];
    end
    if (!bCeN && !bWeN) begin
      if (!bLbN) bMem[bSramAddr][7:0]  <= bDq[7:0];
      if (!bUbN) bMem[bSramAddr][15:8] <= bDq[15:8];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives one request for a cycle, queueing its expected response if one is due.
  task automatic applyStimulus(input bit toB, input bit we, input logic [18:0] addr,
                               input logic [63:0] wdata, input logic [7:0] bmask,
                               input bit expectRsp, input logic [63:0] expRdata);
    exp_t e;
    e.isRead = !we;
    e.data   = expRdata;
    if (!toB) begin
      if (expectRsp) aExpQ.push_back(e);
      aValid = 1'b1; aWe = we; aAddr = addr; aWdata = wdata[31:0]; aBmask = bmask[3:0];
      tick();
      aValid = 1'b0;
    end else begin
      if (expectRsp) bExpQ.push_back(e);
      bValid = 1'b1; bWe = we; bAddr = addr[12:0]; bWdata = wdata; bBmask = bmask;
      tick();
      bValid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (aRspValid === 1'b1) begin
      if (aExpQ.size() == 0) checkOutput("aSpuriousRsp", 64'(aRspValid), 64'd0);
      else begin
        aExp = aExpQ.pop_front();
        if (aExp.isRead) checkOutput("aRspData", {32'h0, aRdata}, aExp.data);
      end
    end
    if (bRspValid === 1'b1) begin
      if (bExpQ.size() == 0) checkOutput("bSpuriousRsp", 64'(bRspValid), 64'd0);
      else begin
        bExp = bExpQ.pop_front();
        if (bExp.isRead) checkOutput("bRspData", bRdata, bExp.data);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      aMem[i] = 16'h0000;
      bMem[i] = 16'h0000;
    end
    bMem[12'h100] = 16'h1111; bMem[12'h101] = 16'h2222;
    bMem[12'h102] = 16'h3333; bMem[12'h103] = 16'h4444;
    bMem[12'h104] = 16'hAAAA; bMem[12'h105] = 16'hBBBB;
    bMem[12'h106] = 16'hCCCC; bMem[12'h107] = 16'hDDDD;

    rstN = 1'b0;
    aValid = 1'b0; aWe = 1'b0; aAddr = '0; aWdata = '0; aBmask = '0;
    bValid = 1'b0; bWe = 1'b0; bAddr = '0; bWdata = '0; bBmask = '0;
    tick();
    tick();
    checkOutput("aResetPins", {aCeN, aWeN, aOeN, aUbN, aLbN}, 5'b11111);
    checkOutput("aResetAddr", aSramAddr, 18'h0);
    checkOutput("aResetRsp", {aRspValid, aBusy}, 2'b00);
    checkOutput("aResetRdata", aRdata, 32'h0);
    checkOutput("bResetPins", {bCeN, bWeN, bOeN, bUbN, bLbN}, 5'b11111);
    rstN = 1'b1;
    tick();
    checkOutput("aReadyAfterReset", aReady, 1'b1);

    // 32-bit full write
    applyStimulus(1'b0, 1'b1, 19'h0100, 64'hDEADBEEF, 8'hF, 1'b1, 64'h0);
    checkOutput("aWrC1Addr", aSramAddr, 18'h080);
    checkOutput("aWrC1Dq", aDq, 16'hBEEF);
    checkOutput("aWrC1Pins", {aCeN, aWeN, aOeN, aUbN, aLbN}, 5'b00100);
    checkOutput("aWrC1BusyReady", {aBusy, aReady}, 2'b10);
    tick();
    checkOutput("aWrC2Addr", aSramAddr, 18'h081);
    checkOutput("aWrC2Dq", aDq, 16'hDEAD);
    checkOutput("aWrC2Rsp", aRspValid, 1'b0);
    tick();
    checkOutput("aWrC3Rsp", {aRspValid, aBusy, aReady}, 3'b101);
    tick();

    // Read back, then a back-to-back partial read accepted in the response cycle
    applyStimulus(1'b0, 1'b0, 19'h0100, 64'h0, 8'hF, 1'b1, 64'hDEADBEEF);
    checkOutput("aRdC1Pins", {aCeN, aWeN, aOeN}, 3'b010);
    checkOutput("aRdC1Addr", aSramAddr, 18'h080);
    tick();
    checkOutput("aRdC2Pins", {aCeN, aWeN, aOeN}, 3'b010);
    checkOutput("aRdC2Addr", aSramAddr, 18'h081);
    tick();
    checkOutput("aRdC3Rsp", {aRspValid, aBusy}, 2'b10);
    checkOutput("aRdC3Data", aRdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 19'h0102, 64'h0, 8'b0110, 1'b1, 64'h00ADBE00);
    checkOutput("aB2bBusy", {aBusy, aCeN, aRspValid}, 3'b100);
    checkOutput("aB2bC1Lanes", {aUbN, aLbN}, 2'b01);
    tick();
    checkOutput("aB2bC2Lanes", {aUbN, aLbN}, 2'b10);
    tick();
    checkOutput("aB2bC3Data", {aRspValid, aRdata}, {1'b1, 32'h00ADBE00});
    tick();

    // Single-byte write skips the masked upper beat
    applyStimulus(1'b0, 1'b1, 19'h0104, 64'h11223344, 8'b0001, 1'b1, 64'h0);
    checkOutput("aByteWrAddr", aSramAddr, 18'h082);
    checkOutput("aByteWrLanes", {aUbN, aLbN}, 2'b10);
    checkOutput("aByteWrDq", aDq, 16'h3344);
    tick();
    checkOutput("aByteWrRsp", {aRspValid, aCeN}, 2'b11);
    tick();
    applyStimulus(1'b0, 1'b0, 19'h0104, 64'h0, 8'hF, 1'b1, 64'h00000044);
    tick();
    tick();
    checkOutput("aByteRdData", {aRspValid, aRdata}, {1'b1, 32'h00000044});
    tick();

    // All-zero mask: response the cycle after accept, no bus cycle
    applyStimulus(1'b0, 1'b1, 19'h0108, 64'h55667788, 8'h0, 1'b1, 64'h0);
    checkOutput("aNoMaskRsp", {aRspValid, aCeN, aBusy}, 3'b110);
    tick();
    checkOutput("aNoMaskAfter", aRspValid, 1'b0);

    // 64-bit read, WAIT_RD=2, upper beats masked off
    applyStimulus(1'b1, 1'b0, 19'h0200, 64'h0, 8'h0F, 1'b1, {32'h0, 32'h22221111});
    for (int c = 1; c <= 7; c++) begin
      checkOutput($sformatf("bRdRspC%0d", c), bRspValid, 64'(c == 7));
      checkOutput($sformatf("bRdCeC%0d", c), bCeN, 64'(c > 6));
      if (c == 1) checkOutput("bRdAddrBeat0", bSramAddr, 12'h100);
      if (c == 4) checkOutput("bRdAddrBeat1", bSramAddr, 12'h101);
      if (c < 7) tick();
    end
    tick();

    // WAIT_WR=3 write aborted by reset during beat 1
    applyStimulus(1'b1, 1'b1, 19'h0400, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'h0);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("bWrWeC%0d", c), bWeN, 64'(c == 4));
      checkOutput($sformatf("bWrAddrC%0d", c), bSramAddr, (c <= 4) ? 64'h200 : 64'h201);
      tick();
    end
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("bAbortPins", {bCeN, bWeN, bOeN}, 3'b111);
    checkOutput("bAbortBusy", {bBusy, bRspValid}, 2'b00);
    tick();
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("bReadyAfterAbort", bReady, 1'b1);

    // Full-width read after the abort
    applyStimulus(1'b1, 1'b0, 19'h0208, 64'h0, 8'hFF, 1'b1, 64'hDDDDCCCCBBBBAAAA);
    for (int c = 1; c <= 13; c++) begin
      checkOutput($sformatf("bFullRspC%0d", c), bRspValid, 64'(c == 13));
      if (c < 13) tick();
    end
    tick();
    tick();

    checkOutput("aQueueDrained", 64'(aExpQ.size()), 64'd0);
    checkOutput("bQueueDrained", 64'(bExpQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
